multicycle_datapath: RTL and testbench

//  Parametrised multi-cycle successor of the single-cycle 8-bit datapath: same 16-bit instr format and

---
 rtl/multicycle_datapath.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: PC/IR, operand latches, 8-entry register file, ALU and a phase FSM
// that shares one req/ready memory port between instruction fetch and data access.
module multicycle_datapath #(
   parameter int unsigned DW     = 8,
   parameter int unsigned AW     = 8,
   parameter int unsigned PC_INC = 4
) (
   input  logic          clk,
   input  logic          reset,
   output logic [15:0]   Instr,
   output logic [2:0]    phase,
   output logic          ctrl_req,
   input  logic          RegWriteA,
   input  logic          RegWriteB,
   input  logic          ImmSrc,
   input  logic          IDmux,
   input  logic          JMux,
   input  logic          MemtoReg,
   input  logic          MemWrite,
   input  logic [3:0]    ALUControl,
   output logic [3:0]    ALUFlags,
   output logic [DW-1:0] ShowData,
   output logic [AW-1:0] PC,
   output logic [DW-1:0] ALUResult,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_ready
);

   localparam int unsigned NREG = 8;
   localparam int unsigned DW1  = DW + 1;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic          req_nxt, we_nxt;
   logic          fetch_done, mem_done;

   logic [15:0]   ir;
   logic [AW-1:0] pc;
   logic [DW-1:0] rd1, rd2, alu_out, mdr;
   logic [3:0]    flags;
   logic [DW-1:0] regs [NREG];

   logic          c_rwa, c_rwb, c_imm, c_idm, c_jmp, c_m2r, c_mw;
   logic [3:0]    c_alu;

   logic [DW-1:0] src_a, src_b, imm, alu_r, result;
   logic [DW:0]   sum, dif;
   logic          alu_c, alu_v;
   logic [2:0]    ra3;

   // State register; the memory strobes are registered alongside it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_FETCH;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
      end else begin
         state   <= state_nxt;
         mem_req <= req_nxt;
         mem_we  <= we_nxt;
      end
   end

   assign fetch_done = (state == S_FETCH) && mem_req && mem_ready;
   assign mem_done   = (state == S_MEM) && mem_req && mem_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (fetch_done) state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (c_jmp)              state_nxt = S_FETCH;
            else if (c_mw || c_m2r) state_nxt = S_MEM;
            else                    state_nxt = S_WB;
         end
         S_MEM:    if (mem_done) state_nxt = c_mw ? S_FETCH : S_WB;
         S_WB:     state_nxt = S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // A completed write leaves one idle cycle before the next fetch request
   always_comb begin
      req_nxt  = 1'b0;
      we_nxt   = 1'b0;
      ctrl_req = (state == S_DECODE);
      mem_addr = (state == S_MEM) ? alu_out[AW-1:0] : pc;
      case (state_nxt)
         S_FETCH: req_nxt = (state != S_MEM);
         S_MEM: begin
            req_nxt = 1'b1;
            we_nxt  = c_mw;
         end
         default: ;
      endcase
   end

   always_comb begin
      src_a = ir[15] ? '0 : rd1;
      imm   = ir[15] ? DW'(ir[7:0]) : (c_idm ? DW'(1) : DW'(ir[2:0]));
      src_b = c_imm ? imm : rd2;
      sum   = {1'b0, src_a} + {1'b0, src_b};
      dif   = {1'b0, src_a} + {1'b0, ~src_b} + DW1'(1);
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (c_alu)
         4'd0: begin
            alu_r = sum[DW-1:0];
            alu_c = sum[DW];
            alu_v = (src_a[DW-1] == src_b[DW-1]) && (sum[DW-1] != src_a[DW-1]);
         end
         4'd1: begin
            alu_r = dif[DW-1:0];
            alu_c = dif[DW];
            alu_v = (src_a[DW-1] != src_b[DW-1]) && (dif[DW-1] != src_a[DW-1]);
         end
         4'd2:    alu_r = src_a & src_b;
         4'd3:    alu_r = src_a | src_b;
         4'd4:    alu_r = src_a ^ src_b;
         4'd5:    alu_r = ~src_a;
         4'd6:    alu_r = {src_a[DW-2:0], 1'b0};
         4'd7:    alu_r = {1'b0, src_a[DW-1:1]};
         4'd8:    alu_r = src_b;
         default: alu_r = '0;
      endcase
   end

   assign result = c_m2r ? mdr : alu_out;
   assign ra3    = ir[15] ? ir[10:8] : ir[5:3];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir      <= '0;
         pc      <= '0;
         rd1     <= '0;
         rd2     <= '0;
         alu_out <= '0;
         mdr     <= '0;
         flags   <= '0;
         c_rwa   <= 1'b0;
         c_rwb   <= 1'b0;
         c_imm   <= 1'b0;
         c_idm   <= 1'b0;
         c_jmp   <= 1'b0;
         c_m2r   <= 1'b0;
         c_mw    <= 1'b0;
         c_alu   <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (fetch_done) begin
            ir <= mem_rdata;
            pc <= pc + AW'(PC_INC);
         end
         if (state == S_DECODE) begin
            rd1   <= regs[ir[5:3]];
            rd2   <= regs[ir[2:0]];
            c_rwa <= RegWriteA;
            c_rwb <= RegWriteB;
            c_imm <= ImmSrc;
            c_idm <= IDmux;
            c_jmp <= JMux;
            c_m2r <= MemtoReg;
            c_mw  <= MemWrite;
            c_alu <= ALUControl;
         end
         if (state == S_EXEC) begin
            alu_out <= alu_r;
            flags   <= {alu_r[DW-1], (alu_r == '0), alu_c, alu_v};
            if (c_jmp) pc <= AW'(ir);
         end
         if (mem_done && !c_mw) mdr <= DW'(mem_rdata);
         // Port A is written last so it wins a same-address collision
         if (state == S_WB) begin
            if (c_rwb) regs[ir[2:0]] <= result;
            if (c_rwa) regs[ra3]     <= result;
         end
      end
   end

   assign Instr     = ir;
   assign phase     = 3'(state);
   assign ALUFlags  = flags;
   assign ShowData  = rd1;
   assign PC        = pc;
   assign ALUResult = alu_out;
   assign mem_wdata = rd2;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboarded bench: acts as memory and control decoder, checks every memory access,
// the decode latch and the EXEC result against queues filled when each program is built.
module tb_multicycle_datapath;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [15:0]   Instr;
   logic [2:0]    phase;
   logic          ctrl_req;
   logic          RegWriteA = 1'b0, RegWriteB = 1'b0, ImmSrc = 1'b0, IDmux = 1'b0;
   logic          JMux = 1'b0, MemtoReg = 1'b0, MemWrite = 1'b0;
   logic [3:0]    ALUControl = '0;
   logic [3:0]    ALUFlags;
   logic [DW-1:0] ShowData;
   logic [AW-1:0] PC;
   logic [DW-1:0] ALUResult;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [15:0]   mem_rdata = '0;
   logic          mem_ready = 1'b0;

   always #5 clk = ~clk;

   multicycle_datapath #(.DW(DW), .AW(AW), .PC_INC(4)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .phase(phase), .ctrl_req(ctrl_req),
      .RegWriteA(RegWriteA), .RegWriteB(RegWriteB), .ImmSrc(ImmSrc), .IDmux(IDmux),
      .JMux(JMux), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUControl(ALUControl),
      .ALUFlags(ALUFlags), .ShowData(ShowData), .PC(PC), .ALUResult(ALUResult),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // Field order: rwa rwb imm idm jmp m2r mw aluc[3:0]
   typedef struct packed {
      logic rwa, rwb, imm, idm, jmp, m2r, mw;
      logic [3:0] aluc;
   } ctrl_t;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      logic [7:0]    stall;
   } mem_txn_t;
   typedef struct packed {
      logic [DW-1:0] res;
      logic [3:0]    flags;
   } alu_exp_t;

   mem_txn_t      mem_q[$];
   ctrl_t         ctrl_q[$];
   logic [DW-1:0] rd1_q[$];
   alu_exp_t      alu_q[$];

   logic [15:0] mem [256];
   int          n_chk = 0, n_fail = 0;
   mem_txn_t    cur;
   logic        have_cur = 1'b0, prev_hs = 1'b0, chk_space = 1'b0;
   logic [2:0]  prev_phase = 3'd0;
   int          req_cycles = 0, stall_left = 0, cyc = 0, last_fetch_cyc = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic add_instr(input logic [AW-1:0] addr, input logic [15:0] word, input ctrl_t c,
                            input logic [DW-1:0] rd1, input logic [DW-1:0] res, input logic [3:0] fl);
      mem[addr] = word;
      mem_q.push_back('{addr: addr, we: 1'b0, wdata: '0, stall: 8'd0});
      ctrl_q.push_back(c);
      rd1_q.push_back(rd1);
      alu_q.push_back('{res: res, flags: fl});
   endtask

   task automatic add_data(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd,
                           input logic [7:0] stall);
      mem_q.push_back('{addr: addr, we: we, wdata: wd, stall: stall});
   endtask

   task automatic clear_sb();
      mem_q.delete(); ctrl_q.delete(); rd1_q.delete(); alu_q.delete();
      have_cur = 1'b0; prev_hs = 1'b0; prev_phase = 3'd0;
   endtask

   // One clock: called and returning at a falling edge
   task automatic cycle();
      ctrl_t c;
      logic  hs;
      hs = 1'b0;
      if (prev_hs) check("req_drop", 32'(mem_req), 32'd0);
      if (prev_phase == 3'd1) begin
         if (rd1_q.size() > 0) check("rd1", 32'(ShowData), 32'(rd1_q.pop_front()));
         else check("rd1_q", 32'(rd1_q.size()), 32'd1);
      end
      if (prev_phase == 3'd2) begin
         if (alu_q.size() > 0) begin
            alu_exp_t a;
            a = alu_q.pop_front();
            check("alu_res", 32'(ALUResult), 32'(a.res));
            check("alu_flags", 32'(ALUFlags), 32'(a.flags));
         end else check("alu_q", 32'(alu_q.size()), 32'd1);
      end
      if (ctrl_req) begin
         c = (ctrl_q.size() > 0) ? ctrl_q.pop_front() : '0;
         {RegWriteA, RegWriteB, ImmSrc, IDmux, JMux, MemtoReg, MemWrite, ALUControl} = c;
      end
      mem_ready = 1'b0;
      if (mem_req && (have_cur || mem_q.size() > 0)) begin
         if (!have_cur) begin
            cur = mem_q.pop_front();
            have_cur = 1'b1;
            req_cycles = 0;
            stall_left = int'(cur.stall);
         end
         req_cycles++;
         mem_rdata = mem[mem_addr];
         if (stall_left > 0) stall_left--;
         else begin
            mem_ready = 1'b1;
            hs = 1'b1;
            check("mem_addr", 32'(mem_addr), 32'(cur.addr));
            check("mem_we", 32'(mem_we), 32'(cur.we));
            check("req_cycles", 32'(req_cycles), 32'(cur.stall) + 32'd1);
            if (cur.we) begin
               check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
               mem[cur.addr] = 16'(cur.wdata);
            end else if (chk_space && phase == 3'd0) begin
               if (last_fetch_cyc >= 0) check("fetch_gap", 32'(cyc - last_fetch_cyc), 32'd4);
               last_fetch_cyc = cyc;
            end
            have_cur = 1'b0;
         end
      end
      prev_hs = hs;
      prev_phase = phase;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int limit);
      int k;
      k = 0;
      while ((mem_q.size() + ctrl_q.size() + rd1_q.size() + alu_q.size()) != 0 || have_cur) begin
         if (k >= limit) break;
         cycle();
         k++;
      end
      check("drain", 32'(mem_q.size() + ctrl_q.size() + rd1_q.size() + alu_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mem_ready = 1'b0;
      {RegWriteA, RegWriteB, ImmSrc, IDmux, JMux, MemtoReg, MemWrite, ALUControl} = '0;
      repeat (2) @(negedge clk);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_pc", 32'(PC), 32'd0);
      check("rst_ir", 32'(Instr), 32'd0);
      check("rst_alu", 32'(ALUResult), 32'd0);
      check("rst_flags", 32'(ALUFlags), 32'd0);
      check("rst_show", 32'(ShowData), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_ctrl_req", 32'(ctrl_req), 32'd0);
      clear_sb();
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;

      // Zero instructions: fetch every 4 cycles, PC wraps past 0xFC
      do_reset();
      chk_space = 1'b1;
      for (int i = 0; i < 66; i++)
         add_instr(AW'(i * 4), 16'h0000, ctrl_t'(11'b0), 8'h00, 8'h00, 4'b0100);
      run(400);
      chk_space = 1'b0;

      // Program exercising immediates, ALU ops, memory write/read and a jump
      do_reset();
      add_instr(8'h00, 16'h8033, ctrl_t'(11'b1_0_1_0_0_0_0_0000), 8'h00, 8'h33, 4'b0000);
      add_instr(8'h04, 16'h8A05, ctrl_t'(11'b1_0_1_0_0_0_0_0000), 8'h33, 8'h05, 4'b0000);
      add_instr(8'h08, 16'h817F, ctrl_t'(11'b1_0_1_0_0_0_0_0000), 8'h00, 8'h7F, 4'b0000);
      add_instr(8'h0C, 16'h8201, ctrl_t'(11'b1_0_1_0_0_0_0_0000), 8'h33, 8'h01, 4'b0000);
      add_instr(8'h10, 16'h000A, ctrl_t'(11'b0_0_0_0_0_0_0_0000), 8'h7F, 8'h80, 4'b1001);
      add_instr(8'h14, 16'h0011, ctrl_t'(11'b0_1_0_0_0_0_0_0001), 8'h01, 8'h82, 4'b1000);
      add_instr(8'h18, 16'h8040, ctrl_t'(11'b0_0_1_0_0_0_1_0000), 8'h33, 8'h40, 4'b0000);
      add_data (8'h40, 1'b1, 8'h33, 8'd3);
      add_instr(8'h1C, 16'h8340, ctrl_t'(11'b1_0_1_0_0_1_0_0000), 8'h33, 8'h40, 4'b0000);
      add_data (8'h40, 1'b0, 8'h00, 8'd0);
      add_instr(8'h20, 16'h001B, ctrl_t'(11'b0_0_0_0_0_0_0_0001), 8'h33, 8'h00, 4'b0110);
      add_instr(8'h24, 16'h0018, ctrl_t'(11'b0_0_1_1_0_0_0_0000), 8'h33, 8'h34, 4'b0000);
      add_instr(8'h28, 16'h000F, ctrl_t'(11'b0_0_1_0_0_0_0_0100), 8'h82, 8'h85, 4'b1000);
      add_instr(8'h2C, 16'h0008, ctrl_t'(11'b0_0_0_0_0_0_0_0110), 8'h82, 8'h04, 4'b0000);
      add_instr(8'h30, 16'h0008, ctrl_t'(11'b0_0_0_0_0_0_0_0111), 8'h82, 8'h41, 4'b0000);
      add_instr(8'h34, 16'h0080, ctrl_t'(11'b1_0_0_0_1_0_0_0000), 8'h33, 8'h66, 4'b0000);
      add_instr(8'h80, 16'h0000, ctrl_t'(11'b0_0_0_0_0_0_0_1000), 8'h33, 8'h33, 4'b0000);
      add_instr(8'h84, 16'h0000, ctrl_t'(11'b0_0_0_0_0_0_0_1001), 8'h33, 8'h00, 4'b0100);
      add_instr(8'h88, 16'h0009, ctrl_t'(11'b0_0_0_0_0_0_0_0000), 8'h82, 8'h04, 4'b0011);
      run(400);

      // Reset asserted while a write waits in MEM
      do_reset();
      add_instr(8'h00, 16'h8033, ctrl_t'(11'b0_0_1_0_0_0_1_0000), 8'h00, 8'h33, 4'b0000);
      add_data (8'h33, 1'b1, 8'h00, 8'd20);
      for (int k = 0; k < 50 && !(phase == 3'd3 && have_cur && req_cycles >= 2); k++) cycle();
      check("mem_wait", 32'(phase), 32'd3);
      check("mem_wait_req", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_req", 32'(mem_req), 32'd0);
      check("abort_phase", 32'(phase), 32'd0);
      check("abort_pc", 32'(PC), 32'd0);
      clear_sb();
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      add_instr(8'h00, 16'h8033, ctrl_t'(11'b0), 8'h00, 8'h00, 4'b0100);
      run(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
